// File: rtl/leg_seq_pkg.sv
// Shared constants, state/class types and opcode decode for the LEG PC sequencer.
// CALL/RET decoding exists only when LEG_CALL_STACK_EN is defined.
package leg_seq_pkg;

  localparam logic [7:0] OP_HALT  = 8'h12;
  localparam logic [7:0] OP_CALL  = 8'h10;
  localparam logic [7:0] OP_RET   = 8'h11;
  localparam int         COND_BIT = 5;
  localparam logic [7:0] PC_STEP  = 8'd4;

  typedef enum logic {RUN, HALT} seq_state_t;

  typedef enum logic [2:0] {
    CLS_SEQ,
    CLS_JMP,
    CLS_HALT,
    CLS_CALL,
    CLS_RET
  } instr_cls_t;

  function automatic instr_cls_t decode_class(input logic [7:0] op);
    if (op[COND_BIT]) return CLS_JMP;
    if (op == OP_HALT) return CLS_HALT;
`ifdef LEG_CALL_STACK_EN
    if (op == OP_CALL) return CLS_CALL;
    if (op == OP_RET)  return CLS_RET;
`endif
    return CLS_SEQ;
  endfunction

endpackage

// File: rtl/leg_return_stack.sv
// Small LIFO of return addresses; push and pop are ignored when full/empty.
// clear_i empties the stack (used by restart).
module leg_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] top_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [AW-1:0] top_idx;

  assign full_o  = (sp_q == PW'(DEPTH));
  assign empty_o = (sp_q == '0);
  // Low bits wrap to DEPTH-1 when full, which is the newest entry.
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign top_o   = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (clear_i)                sp_d = '0;
    else if (push_i && !full_o) sp_d = sp_q + PW'(1);
    else if (pop_i && !empty_o) sp_d = sp_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clear_i) mem_q[sp_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/leg_pc_sequencer.sv
// Program-counter sequencer for the 8-bit LEG core: PC step/jump, HALT and restart.
// Define LEG_CALL_STACK_EN to enable CALL/RET through a return stack.
module leg_pc_sequencer
  import leg_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] opcode,
  input  logic [7:0] target,
  input  logic       cond_true,
  input  logic       restart,
  output logic [7:0] pc,
  output logic       halted,
  output logic [7:0] retired,
  output logic       stack_err
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 8 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("STACK_DEPTH must be a power of two in 2..8");
  end

  seq_state_t state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] retired_q, retired_d;
  logic [7:0] pc_plus4;
  instr_cls_t cls;
  logic       accept;

  assign cls      = decode_class(opcode);
  assign accept   = instr_valid && (state_q == RUN);
  assign pc_plus4 = pc_q + PC_STEP;

`ifdef LEG_CALL_STACK_EN
  logic       stk_full, stk_empty, stk_push, stk_pop;
  logic [7:0] stk_top;
  logic       stack_err_q, stack_err_d;

  assign stk_push = accept && !restart && (cls == CLS_CALL);
  assign stk_pop  = accept && !restart && (cls == CLS_RET);

  leg_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (8)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clear_i (restart),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_plus4),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .top_o   (stk_top)
  );

  always_comb begin
    stack_err_d = stack_err_q;
    if (restart) stack_err_d = 1'b0;
    else if ((stk_push && stk_full) || (stk_pop && stk_empty)) stack_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stack_err_q <= 1'b0;
    else     stack_err_q <= stack_err_d;
  end

  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (!restart && accept && cls == CLS_HALT) state_d = HALT;
      HALT: if (restart) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == RUN);
    halted      = (state_q == HALT);
  end

  // Restart outranks any instruction accepted in the same cycle.
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    if (restart) begin
      pc_d      = RESET_PC;
      retired_d = 8'h00;
    end else if (accept) begin
      retired_d = retired_q + 8'd1;
      case (cls)
        CLS_JMP:  pc_d = cond_true ? target : pc_plus4;
        CLS_HALT: pc_d = pc_q;
`ifdef LEG_CALL_STACK_EN
        CLS_CALL: pc_d = target;
        CLS_RET:  pc_d = stk_empty ? pc_plus4 : stk_top;
`endif
        default:  pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      retired_q <= 8'h00;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_leg_pc_sequencer.sv
// Directed bench for leg_pc_sequencer; CALL/RET checks run when LEG_CALL_STACK_EN is defined.
module tb_leg_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst, instr_valid, cond_true, restart;
  logic [7:0] opcode, target;
  logic       instr_ready, halted, stack_err;
  logic [7:0] pc, retired;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_ret;

  always #5 clk = ~clk;

  leg_pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .target      (target),
    .cond_true   (cond_true),
    .restart     (restart),
    .pc          (pc),
    .halted      (halted),
    .retired     (retired),
    .stack_err   (stack_err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] tgt, input logic c);
    instr_valid = 1'b1;
    opcode      = op;
    target      = tgt;
    cond_true   = c;
    step();
    instr_valid = 1'b0;
    cond_true   = 1'b0;
    exp_ret     = exp_ret + 8'd1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    exp_ret = 8'h00;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; cond_true = 1'b0; restart = 1'b0;
    opcode = 8'h00; target = 8'h00; exp_ret = 8'h00;
    step(); step();
    rst = 1'b0;
    check("rst_pc", pc, 8'h00);
    check("rst_ready", {7'b0, instr_ready}, 8'h01);
    check("rst_halted", {7'b0, halted}, 8'h00);
    check("rst_retired", retired, 8'h00);
    check("rst_stack_err", {7'b0, stack_err}, 8'h00);

    issue(8'h00, 8'h00, 1'b0); check("seq1", pc, 8'h04);
    issue(8'h00, 8'h00, 1'b0); check("seq2", pc, 8'h08);
    issue(8'h00, 8'h00, 1'b0); check("seq3", pc, 8'h0C);
    check("retired3", retired, 8'h03);

    issue(8'h20, 8'h40, 1'b1); check("jmp_taken", pc, 8'h40);
    issue(8'h20, 8'h40, 1'b0); check("jmp_not_taken", pc, 8'h44);
    issue(8'h05, 8'h90, 1'b1); check("cond_ignored", pc, 8'h48);
    issue(8'hFF, 8'h43, 1'b1); check("target_verbatim", pc, 8'h43);
    step();                    check("idle_hold", pc, 8'h43);
    check("idle_retired", retired, 8'h07);

    issue(8'h20, 8'hFC, 1'b1); check("jmp_fc", pc, 8'hFC);
    issue(8'h00, 8'h00, 1'b0); check("pc_wrap", pc, 8'h00);

    for (int i = 0; i < 300 && exp_ret != 8'hFF; i++) issue(8'h01, 8'h00, 1'b0);
    check("retired_ff", retired, 8'hFF);
    issue(8'h01, 8'h00, 1'b0);
    check("retired_wrap", retired, 8'h00);

    issue(8'h20, 8'h10, 1'b1); check("jmp_10", pc, 8'h10);
    issue(8'h12, 8'h00, 1'b0);
    check("halt_pc", pc, 8'h10);
    check("halt_halted", {7'b0, halted}, 8'h01);
    check("halt_ready", {7'b0, instr_ready}, 8'h00);
    check("halt_retired", retired, exp_ret);
    instr_valid = 1'b1; opcode = 8'h20; target = 8'h77; cond_true = 1'b1;
    step(); step(); step();
    instr_valid = 1'b0; cond_true = 1'b0;
    check("halt_ignore_pc", pc, 8'h10);
    check("halt_ignore_ret", retired, exp_ret);
    do_restart();
    check("restart_pc", pc, 8'h00);
    check("restart_halted", {7'b0, halted}, 8'h00);
    check("restart_ready", {7'b0, instr_ready}, 8'h01);
    check("restart_retired", retired, 8'h00);

    issue(8'h20, 8'h30, 1'b1); check("jmp_30", pc, 8'h30);
    restart = 1'b1;
    issue(8'h20, 8'h50, 1'b1);
    restart = 1'b0; exp_ret = 8'h00;
    check("restart_prio_pc", pc, 8'h00);
    check("restart_prio_ret", retired, 8'h00);

`ifdef LEG_CALL_STACK_EN
    issue(8'h10, 8'h80, 1'b0); check("call1", pc, 8'h80);
    issue(8'h10, 8'h80, 1'b0); check("call2", pc, 8'h80);
    issue(8'h10, 8'h80, 1'b0); check("call3", pc, 8'h80);
    issue(8'h10, 8'h80, 1'b0); check("call4", pc, 8'h80);
    check("call4_err", {7'b0, stack_err}, 8'h00);
    issue(8'h10, 8'h80, 1'b0); check("call5", pc, 8'h80);
    check("call5_err", {7'b0, stack_err}, 8'h01);
    issue(8'h11, 8'h00, 1'b0); check("ret1", pc, 8'h84);
    issue(8'h11, 8'h00, 1'b0); check("ret2", pc, 8'h84);
    issue(8'h11, 8'h00, 1'b0); check("ret3", pc, 8'h84);
    issue(8'h11, 8'h00, 1'b0); check("ret4", pc, 8'h04);
    issue(8'h11, 8'h00, 1'b0); check("ret_empty", pc, 8'h08);
    check("ret_empty_err", {7'b0, stack_err}, 8'h01);
    do_restart();
    check("restart_clr_err", {7'b0, stack_err}, 8'h00);
    issue(8'h11, 8'h00, 1'b0); check("ret_after_clr", pc, 8'h04);
    check("ret_after_clr_err", {7'b0, stack_err}, 8'h01);
    do_restart();
`else
    issue(8'h10, 8'h80, 1'b0); check("call_as_seq", pc, 8'h04);
    issue(8'h11, 8'h80, 1'b0); check("ret_as_seq", pc, 8'h08);
    check("no_stack_err", {7'b0, stack_err}, 8'h00);
`endif

    issue(8'h20, 8'h30, 1'b1); check("pre_rst_pc", pc, 8'h30);
    rst = 1'b1; restart = 1'b1;
    issue(8'h20, 8'h70, 1'b1);
    rst = 1'b0; restart = 1'b0;
    check("rst_prio_pc", pc, 8'h00);
    check("rst_prio_ready", {7'b0, instr_ready}, 8'h01);
    check("rst_prio_halted", {7'b0, halted}, 8'h00);
    check("rst_prio_retired", retired, 8'h00);
    check("rst_prio_err", {7'b0, stack_err}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
